ste_dma_fifo: RTL and testbench
===============================

STE_DMA_FIFO -- requirements
Module: ste_dma_fifo

Interface
REQ-001 Parameter DW, default 16, data word width; SHALL be at least 16, and only bits [15:0] take part in register access.
REQ-002 Parameter DEPTH, default 16, FIFO depth in words; SHALL be a power of two and at least 4.
REQ-003 Parameter BURST, default 8, words per RDY burst; SHALL satisfy 1 <= BURST <= DEPTH.
REQ-004 clk32  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 clk_en  in  1  8 MHz bus enable; every bus-side sampling SHALL be qualified by it.
REQ-007 FCS_N  in  1  register chip select, active low.
REQ-008 RW  in  1  bus direction; 1 = read.
REQ-009 A1  in  1  register select; 0 = transfer counter, 1 = control/status.
REQ-010 DIN  in  DW  bus write data.
REQ-011 DOUT  out  DW  bus read data.
REQ-012 RDY_O  out  1  DMA request to the MCU, active low.
REQ-013 RDY_I  in  1  MCU word strobe, active low.
REQ-014 dev_in_valid / dev_in_data[DW] / dev_in_ready  in/in/out  device-to-memory stream.
REQ-015 dev_out_valid / dev_out_data[DW] / dev_out_ready  out/out/in  memory-to-device stream.
REQ-016 level  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-017 err  out  1  sticky overrun/underrun flag.

Function
REQ-018 Control write: FCS_N=0, A1=1, RW=0, clk_en=1.
- DIN[0] = dir: 1 = device to memory, 0 = memory to device.
- DIN[1] = flush, self-clearing.
- DIN[2] = enable.
- The write SHALL also clear the transfer counter and err.
REQ-019 Status read (A1=1, RW=1) SHALL return {level, err, state[1:0], enable, dir} in LSBs, zero-padded; counter read (A1=0, RW=1) SHALL return the 16-bit transfer counter.
REQ-020 Flush SHALL empty the FIFO, force state IDLE and deassert RDY_O on the next clk32 edge, including mid-burst.
REQ-021 dev_in_ready SHALL be enable & dir & ~full, combinational.
- A push occurs when dev_in_valid & dev_in_ready, on any clk32 edge.
REQ-022 dev_out_valid SHALL be enable & ~dir & ~empty, combinational.
- dev_out_data SHALL be the FIFO head; a pop occurs when dev_out_valid & dev_out_ready.
REQ-023 States are IDLE, REQ, XFER, GAP; state advances only on clk_en, except for flush and reset.
REQ-024 IDLE->REQ when enable and threshold met.
- dir=1: level >= BURST.
- dir=0: DEPTH-level >= BURST.
- dir SHALL be latched at this transition as bdir.
REQ-025 REQ and XFER SHALL drive RDY_O=0; IDLE and GAP SHALL drive RDY_O=1.
REQ-026 In REQ or XFER, a word SHALL transfer on each clk_en with RDY_I=0.
- bdir=1: pop; DOUT = FIFO head during REQ/XFER when FCS_N=1.
- bdir=0: push DIN.
- Each word SHALL increment the burst counter and the 16-bit transfer counter (which wraps at 0xFFFF->0).
REQ-027 REQ->XFER on the first word; XFER->GAP when the burst counter reaches BURST; GAP->IDLE on the next clk_en.
REQ-028 A bus pop while empty or a bus push while full SHALL be ignored and SHALL set err.
- Such a strobe still counts toward the burst, so the burst terminates.
REQ-029 Simultaneous device-side and bus-side push/pop in one cycle SHALL both complete, with level unchanged.
- A push when full is rejected unless a pop occurs in the same cycle.
REQ-030 Clearing enable mid-burst SHALL complete the current burst; a dir change SHALL affect only the next burst.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-032 DOUT SHALL be 0 when there is no register read and no bdir=1 burst is active.

Reset
REQ-033 On reset=1 at a clk32 edge the block SHALL set:
- state IDLE, RDY_O=1, DOUT=0;
- FIFO empty (level=0), err=0, counters=0;
- enable=0, dir=0, so that dev_in_ready=0 and dev_out_valid=0.
REQ-034 Reset SHALL override any concurrent control write or transfer in the same cycle.

Verification
REQ-035 Reset, write ctrl 0x5, push 8 words 0x1000..0x1007 -> RDY_O=0 at the clk_en after level=8; 8 RDY_I strobes return 0x1000..0x1007 in order; RDY_O=1 in GAP; counter=8.
REQ-036 dir=0, enable: RDY_O=0 immediately (level=0); bus writes 0xA000..0xA007 -> dev_out_data yields them in order; level returns to 0.
REQ-037 Flush written after 3 words of an 8-word burst -> RDY_O=1 next clk32, level=0, state IDLE.
REQ-038 dir=1, BURST=8, 9 RDY_I strobes with 7 words present -> 8th strobe sets err=1; burst ends after the 8th strobe; the 9th is ignored (no state change).
REQ-039 Device push and bus pop in the same cycle at level=DEPTH -> both accepted, level stays DEPTH.
REQ-040 Counter preloaded to 0xFFFE by 0xFFFE transfers, then 2 more -> counter reads 0x0000.

Source files
------------

// File: rtl/ste_dma_fifo.sv
// DMA staging FIFO between a peripheral stream and the MCU RDY bus.
// The FIFO fills or drains in RDY bursts, with a counter and status register.
module ste_dma_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int BURST = 8
) (
  input  logic                     clk32,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic                     FCS_N,
  input  logic                     RW,
  input  logic                     A1,
  input  logic [DW-1:0]            DIN,
  output logic [DW-1:0]            DOUT,
  output logic                     RDY_O,
  input  logic                     RDY_I,
  input  logic                     dev_in_valid,
  input  logic [DW-1:0]            dev_in_data,
  output logic                     dev_in_ready,
  output logic                     dev_out_valid,
  output logic [DW-1:0]            dev_out_data,
  input  logic                     dev_out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic            enable, dir, bdir;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [LW-1:0]   cnt;
  logic [BW-1:0]   bcnt, bcnt_nx;
  logic [15:0]     tcnt;
  logic [15:0]     stat;

  logic ctrl_wr, flush, busy, strobe;
  logic empty, full, thresh;
  logic dev_push, dev_pop, bus_push, bus_pop;
  logic push, pop, miss;

  assign ctrl_wr = clk_en & ~FCS_N & A1 & ~RW;
  assign flush   = ctrl_wr & DIN[1];
  assign busy    = (state == REQ) || (state == XFER);
  assign strobe  = clk_en & busy & ~RDY_I;
  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));

  assign dev_out_valid = enable & ~dir & ~empty;
  assign dev_out_data  = mem[rptr];
  assign dev_pop       = dev_out_valid & dev_out_ready;

  // A second same-side access in one cycle is treated as an over/underrun.
  assign bus_pop      = strobe & bdir & ~empty & ~dev_pop;
  assign dev_in_ready = enable & dir & (~full | bus_pop);
  assign dev_push     = dev_in_valid & dev_in_ready;
  assign bus_push     = strobe & ~bdir & (~full | dev_pop) & ~dev_push;

  assign push = dev_push | bus_push;
  assign pop  = dev_pop | bus_pop;
  assign miss = strobe & ~(bus_push | bus_pop);

  assign thresh = dir ? (cnt >= LW'(BURST))
                      : ((LW'(DEPTH) - cnt) >= LW'(BURST));

  assign RDY_O = ~busy;
  assign level = cnt;
  assign stat  = 16'({cnt, err, logic'(state[1]), logic'(state[0]),
                      enable, dir});

  always_comb begin
    state_nx = state;
    bcnt_nx  = bcnt;
    if (strobe) bcnt_nx = bcnt + BW'(1);
    if (clk_en) begin
      unique case (state)
        IDLE: if (enable && thresh) begin
          state_nx = REQ;
          bcnt_nx  = '0;
        end
        REQ, XFER: if (strobe)
          state_nx = (bcnt_nx == BW'(BURST)) ? GAP : XFER;
        GAP:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
    if (flush) begin
      state_nx = IDLE;
      bcnt_nx  = '0;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state  <= IDLE;
      bcnt   <= '0;
      enable <= 1'b0;
      dir    <= 1'b0;
      bdir   <= 1'b0;
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      tcnt   <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      bcnt  <= bcnt_nx;
      if (state == IDLE && state_nx == REQ) bdir <= dir;
      if (ctrl_wr) begin
        dir    <= DIN[0];
        enable <= DIN[2];
      end
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        cnt <= cnt + LW'(push) - LW'(pop);
      end
      if (ctrl_wr) begin
        tcnt <= '0;
        err  <= 1'b0;
      end else begin
        if (bus_push || bus_pop) tcnt <= tcnt + 16'd1;
        if (miss) err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (push && !flush && !reset)
      mem[wptr] <= dev_push ? dev_in_data : DIN;
  end

  always_comb begin
    DOUT = '0;
    if (!FCS_N && RW) DOUT[15:0] = A1 ? stat : tcnt;
    else if (busy && bdir) DOUT = mem[rptr];
  end

endmodule

// File: tb/tb_ste_dma_fifo.sv
// Bench for ste_dma_fifo: control table, scoreboarded bursts,
// flush/underrun/full-swap corners and a 16-bit counter wrap.
module tb_ste_dma_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clk_en, fcs_n, rw, a1, rdy_i, div, dor;
  logic [15:0] din, did, dout, dod;
  logic        rdy_o, dir_rdy, dov, err;
  logic [4:0]  level;

  logic        w_reset, w_en, w_fcs, w_rw, w_a1, w_rdyi, w_div, w_dor;
  logic [15:0] w_din, w_did, w_dout, w_dod;
  logic        w_rdyo, w_irdy, w_ovld, w_err;
  logic [6:0]  w_level;

  ste_dma_fifo dut (
    .clk32(clk), .reset(reset), .clk_en(clk_en), .FCS_N(fcs_n),
    .RW(rw), .A1(a1), .DIN(din), .DOUT(dout), .RDY_O(rdy_o),
    .RDY_I(rdy_i), .dev_in_valid(div), .dev_in_data(did),
    .dev_in_ready(dir_rdy), .dev_out_valid(dov),
    .dev_out_data(dod), .dev_out_ready(dor), .level(level),
    .err(err)
  );

  ste_dma_fifo #(.DW(16), .DEPTH(64), .BURST(64)) u_wrap (
    .clk32(clk), .reset(w_reset), .clk_en(w_en), .FCS_N(w_fcs),
    .RW(w_rw), .A1(w_a1), .DIN(w_din), .DOUT(w_dout),
    .RDY_O(w_rdyo), .RDY_I(w_rdyi), .dev_in_valid(w_div),
    .dev_in_data(w_did), .dev_in_ready(w_irdy),
    .dev_out_valid(w_ovld), .dev_out_data(w_dod),
    .dev_out_ready(w_dor), .level(w_level), .err(w_err)
  );

  int ncmp = 0;
  int nerr = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic [15:0] ctrl;
    logic [15:0] stat;
    logic        irdy;
    logic        ovld;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic sb_chk(input string name, input logic [15:0] act);
    logic [15:0] e;
    if (sb.size() == 0) begin
      ncmp++;
      nerr++;
      $display("FAIL %s: got %h, scoreboard empty", name, act);
    end else begin
      e = sb.pop_front();
      chk(name, act, e);
    end
  endtask

  task automatic cyc(input logic en, input logic f, input logic r,
                     input logic a, input logic [15:0] d,
                     input logic ri, output logic [15:0] q);
    clk_en = en; fcs_n = f; rw = r; a1 = a; din = d; rdy_i = ri;
    #2;
    q = dout;
    @(posedge clk); #1;
    clk_en = 1'b0; fcs_n = 1'b1; rw = 1'b1; a1 = 1'b0;
    din = '0; rdy_i = 1'b1;
  endtask

  task automatic slow();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wr_ctrl(input logic [15:0] v);
    logic [15:0] q;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, v, 1'b1, q);
    slow();
  endtask

  task automatic rd(input logic sel, output logic [15:0] q);
    cyc(1'b1, 1'b0, 1'b1, sel, 16'h0, 1'b1, q);
    slow();
  endtask

  task automatic strobe(input logic [15:0] d, output logic [15:0] q);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, d, 1'b0, q);
    slow();
  endtask

  task automatic en_idle();
    logic [15:0] q;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, q);
    slow();
  endtask

  task automatic dev_push(input logic [15:0] d);
    chk("in_ready", dir_rdy, 1'b1);
    div = 1'b1; did = d;
    @(posedge clk); #1;
    div = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] q;
    int n, cycles;

    reset = 1'b1; clk_en = 1'b0; fcs_n = 1'b1; rw = 1'b1; a1 = 1'b0;
    din = '0; did = '0; rdy_i = 1'b1; div = 1'b0; dor = 1'b0;
    w_reset = 1'b1; w_en = 1'b0; w_fcs = 1'b1; w_rw = 1'b1;
    w_a1 = 1'b0; w_din = '0; w_did = '0; w_rdyi = 1'b1;
    w_div = 1'b0; w_dor = 1'b0;

    tbl[0] = '{16'h0, 16'h0, 1'b0, 1'b0};
    tbl[1] = '{16'h1, 16'h1, 1'b0, 1'b0};
    tbl[2] = '{16'h4, 16'h2, 1'b0, 1'b0};
    tbl[3] = '{16'h5, 16'h3, 1'b1, 1'b0};
    tbl[4] = '{16'h3, 16'h1, 1'b0, 1'b0};
    tbl[5] = '{16'h6, 16'h2, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_rdy_o", rdy_o, 1'b1);
    chk("rst_dout", dout, 16'h0);
    chk("rst_level", level, 5'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_in_ready", dir_rdy, 1'b0);
    chk("rst_out_valid", dov, 1'b0);

    foreach (tbl[i]) begin
      wr_ctrl(tbl[i].ctrl);
      chk("tbl_in_ready", dir_rdy, tbl[i].irdy);
      chk("tbl_out_valid", dov, tbl[i].ovld);
      rd(1'b1, q);
      chk("tbl_status", q, tbl[i].stat);
      wr_ctrl(16'h2);
    end

    // device-to-memory burst
    wr_ctrl(16'h5);
    for (int i = 0; i < 8; i++) begin
      dev_push(16'h1000 + 16'(i));
      sb.push_back(16'h1000 + 16'(i));
    end
    chk("d2m_level", level, 5'd8);
    chk("d2m_rdy_pre", rdy_o, 1'b1);
    en_idle();
    chk("d2m_rdy_req", rdy_o, 1'b0);
    for (int i = 0; i < 8; i++) begin
      strobe(16'h0, q);
      sb_chk("d2m_word", q);
    end
    chk("d2m_rdy_gap", rdy_o, 1'b1);
    chk("d2m_level_end", level, 5'd0);
    rd(1'b1, q);
    chk("d2m_status_gap", q, 16'h000F);
    rd(1'b0, q);
    chk("d2m_counter", q, 16'd8);

    // memory-to-device burst
    wr_ctrl(16'h4);
    en_idle();
    chk("m2d_rdy_req", rdy_o, 1'b0);
    for (int i = 0; i < 8; i++) begin
      strobe(16'hA000 + 16'(i), q);
      sb.push_back(16'hA000 + 16'(i));
    end
    chk("m2d_rdy_gap", rdy_o, 1'b1);
    chk("m2d_level", level, 5'd8);
    dor = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("m2d_valid", dov, 1'b1);
      sb_chk("m2d_word", dod);
      @(posedge clk); #1;
    end
    dor = 1'b0;
    chk("m2d_level_end", level, 5'd0);
    chk("m2d_valid_end", dov, 1'b0);

    // flush in the middle of a burst
    wr_ctrl(16'h2);
    wr_ctrl(16'h5);
    for (int i = 0; i < 8; i++) begin
      dev_push(16'h3000 + 16'(i));
      sb.push_back(16'h3000 + 16'(i));
    end
    en_idle();
    for (int i = 0; i < 3; i++) begin
      strobe(16'h0, q);
      sb_chk("flush_word", q);
    end
    chk("flush_level_pre", level, 5'd5);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h3, 1'b1, q);
    chk("flush_rdy_o", rdy_o, 1'b1);
    chk("flush_level", level, 5'd0);
    slow();
    rd(1'b1, q);
    chk("flush_status", q, 16'h0001);
    sb.delete();

    // underrun: burst with one word short
    wr_ctrl(16'h5);
    for (int i = 0; i < 8; i++) begin
      dev_push(16'h4000 + 16'(i));
      sb.push_back(16'h4000 + 16'(i));
    end
    en_idle();
    chk("udr_rdy_req", rdy_o, 1'b0);
    wr_ctrl(16'h4);
    chk("udr_out_valid", dov, 1'b1);
    dor = 1'b1;
    sb_chk("udr_dev_word", dod);
    @(posedge clk); #1;
    dor = 1'b0;
    chk("udr_level", level, 5'd7);
    for (int i = 1; i <= 9; i++) begin
      strobe(16'h0, q);
      if (i <= 7) sb_chk("udr_word", q);
      if (i == 7) begin
        chk("udr_err_7", err, 1'b0);
        chk("udr_rdy_7", rdy_o, 1'b0);
      end
      if (i == 8) begin
        chk("udr_err_8", err, 1'b1);
        chk("udr_rdy_8", rdy_o, 1'b1);
      end
    end
    chk("udr_level_end", level, 5'd0);
    chk("udr_err_end", err, 1'b1);
    rd(1'b0, q);
    chk("udr_counter", q, 16'd7);

    // full FIFO: device push and bus pop together
    wr_ctrl(16'h3);
    wr_ctrl(16'h5);
    for (int i = 0; i < 16; i++) begin
      dev_push(16'h2000 + 16'(i));
      sb.push_back(16'h2000 + 16'(i));
    end
    chk("full_level", level, 5'd16);
    chk("full_in_ready", dir_rdy, 1'b0);
    en_idle();
    div = 1'b1; did = 16'hBEEF; clk_en = 1'b1; rdy_i = 1'b0;
    #2;
    chk("swap_in_ready", dir_rdy, 1'b1);
    sb_chk("swap_word", dout);
    sb.push_back(16'hBEEF);
    @(posedge clk); #1;
    div = 1'b0; clk_en = 1'b0; rdy_i = 1'b1;
    chk("swap_level", level, 5'd16);
    slow();
    for (int i = 0; i < 7; i++) begin
      strobe(16'h0, q);
      sb_chk("swap_rest", q);
    end
    chk("swap_level_gap", level, 5'd9);
    en_idle();
    en_idle();
    for (int i = 0; i < 8; i++) begin
      strobe(16'h0, q);
      sb_chk("wrap_ptr_word", q);
    end
    chk("wrap_ptr_level", level, 5'd1);
    sb.delete();

    // reset beats a concurrent control write
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h5, 1'b1, q);
    reset = 1'b0;
    chk("rst2_rdy_o", rdy_o, 1'b1);
    chk("rst2_level", level, 5'd0);
    chk("rst2_in_ready", dir_rdy, 1'b0);
    rd(1'b1, q);
    chk("rst2_status", q, 16'h0);

    // transfer counter wrap on a deep, long-burst instance
    @(posedge clk); #1;
    w_reset = 1'b0; w_en = 1'b1;
    w_fcs = 1'b0; w_rw = 1'b0; w_a1 = 1'b1; w_din = 16'h4;
    @(posedge clk); #1;
    w_fcs = 1'b1; w_rw = 1'b1; w_din = '0; w_dor = 1'b1;
    n = 0;
    cycles = 0;
    while (n < 32'hFFFE && cycles < 80000) begin
      w_rdyi = w_rdyo;
      if (!w_rdyo) n++;
      @(posedge clk); #1;
      cycles++;
    end
    w_rdyi = 1'b1;
    chk("wrap_budget_1", n, 32'hFFFE);
    w_fcs = 1'b0; w_a1 = 1'b0;
    #1;
    chk("cnt_fffe", w_dout, 16'hFFFE);
    w_fcs = 1'b1;
    @(posedge clk); #1;
    while (n < 32'h10000 && cycles < 82000) begin
      w_rdyi = w_rdyo;
      if (!w_rdyo) n++;
      @(posedge clk); #1;
      cycles++;
    end
    w_rdyi = 1'b1;
    chk("wrap_budget_2", n, 32'h10000);
    w_fcs = 1'b0; w_a1 = 1'b0;
    #1;
    chk("cnt_wrap", w_dout, 16'h0000);
    chk("wrap_err", w_err, 1'b0);
    w_fcs = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
